half_adder_pipe: RTL and testbench

- Registered bank of WIDTH independent 1-bit half adders.
- Each lane computes sum = a XOR b and carry = a AND b. Results are registered with one-cycle latency and a valid flag.
- A saturating counter tracks how many accepted lanes produced a carry, for datapath occupancy/statistics monitoring.
- Sits as a leaf arithmetic primitive feeding wider adder/compressor stages.

---
 rtl/half_adder_pipe.sv | 97 +++++++++
 tb/tb_half_adder_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/half_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : half_adder_pipe
// Purpose  : Registered bank of WIDTH independent 1-bit half adders with a
//            one-cycle latency valid flag and a saturating counter of
//            carry-producing lanes over all accepted beats.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous active-high reset
//            in_valid  - qualifies a/b this cycle
//            a, b      - operands, one bit per lane
//            clr_cnt   - synchronous clear of carry_cnt (wins over increment)
//            out_valid - sum/carry hold a new result
//            sum       - registered a ^ b
//            carry     - registered a & b
//            carry_cnt - saturating count of lanes with carry=1
// Revision : 1.0 - initial release
// ============================================================================
module half_adder_pipe #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [CNT_W-1:0] carry_cnt
);

    // Width needed to hold a popcount of 0..WIDTH.
    localparam int c_POP_W = $clog2(WIDTH + 1);
    // Accumulator is one bit wider than the larger operand so that the
    // addition can never overflow before the saturation compare.
    localparam int c_ACC_W = ((CNT_W > c_POP_W) ? CNT_W : c_POP_W) + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0]   w_and;
    logic [c_POP_W-1:0] w_pop;
    logic [c_ACC_W-1:0] w_acc;
    logic [CNT_W-1:0]   w_cnt_next;

    logic               r_valid;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   r_carry;
    logic [CNT_W-1:0]   r_cnt;

    assign w_and = a & b;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_POP_W'(w_and[i]);
        end
    end

    assign w_acc      = c_ACC_W'(r_cnt) + c_ACC_W'(w_pop);
    assign w_cnt_next = (w_acc > c_ACC_W'(c_CNT_MAX)) ? c_CNT_MAX
                                                      : w_acc[CNT_W-1:0];

    // Datapath: sum/carry only load on accepted beats, so they stay stable
    // while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= a ^ b;
                r_carry <= w_and;
            end
        end
    end

    // Carry-event statistics counter; clear beats discard their own carries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            r_cnt <= w_cnt_next;
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign carry_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_half_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_adder_pipe
// Purpose  : Self-checking bench for half_adder_pipe. Three instances cover
//            the single-lane truth table, an 8-lane/16-bit-counter datapath
//            and an 8-lane/4-bit-counter saturation case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_adder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Single-lane instance
    logic        v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic        ov1, s1, k1;
    logic [15:0] n1;

    // Eight-lane instance, 16-bit counter
    logic        v8 = 1'b0, cl8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ov8;
    logic [7:0]  s8, k8;
    logic [15:0] n8;

    // Eight-lane instance, 4-bit counter
    logic        vs = 1'b0, cls = 1'b0;
    logic [7:0]  a_s = '0, b_s = '0;
    logic        ovs;
    logic [7:0]  ss, ks;
    logic [3:0]  ns;

    half_adder_pipe #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .clr_cnt(c1),
        .out_valid(ov1), .sum(s1), .carry(k1), .carry_cnt(n1)
    );

    half_adder_pipe #(.WIDTH(8), .CNT_W(16)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .clr_cnt(cl8),
        .out_valid(ov8), .sum(s8), .carry(k8), .carry_cnt(n8)
    );

    half_adder_pipe #(.WIDTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(vs), .a(a_s), .b(b_s), .clr_cnt(cls),
        .out_valid(ovs), .sum(ss), .carry(ks), .carry_cnt(ns)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the eight-lane instance
    logic       m_v;
    logic [7:0] m_sum, m_car;
    int         m_cnt;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } tt_t;
    tt_t tt[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_v   = 1'b0;
        m_sum = '0;
        m_car = '0;
        m_cnt = 0;
    endtask

    // Drive one beat into the eight-lane instance, advance one clock and
    // compare against the model's view of the spec.
    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic clr, input string nm);
        v8 = v; a8 = a; b8 = b; cl8 = clr;
        tick();
        m_v = v;
        if (v) begin
            m_sum = a ^ b;
            m_car = a & b;
        end
        if (clr)
            m_cnt = 0;
        else if (v)
            m_cnt = (m_cnt + $countones(a & b) > 65535) ? 65535
                                                       : m_cnt + $countones(a & b);
        check({nm, ".out_valid"}, ov8, m_v);
        check({nm, ".sum"},       s8,  m_sum);
        check({nm, ".carry"},     k8,  m_car);
        check({nm, ".carry_cnt"}, n8,  m_cnt);
    endtask

    initial begin
        tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tt[1] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tt[2] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};
        model_reset();

        // Reset state
        repeat (2) tick();
        check("rst.ov1", ov1, 0);
        check("rst.cnt1", n1, 0);
        check("rst.ov8", ov8, 0);
        check("rst.sum8", s8, 0);
        check("rst.carry8", k8, 0);
        check("rst.cnt8", n8, 0);
        check("rst.cnts", ns, 0);
        rst = 1'b0;

        // Exhaustive single-lane truth table, back-to-back beats
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1; a1 = tt[i].a; b1 = tt[i].b;
            tick();
            check($sformatf("tt%0d.valid", i), ov1, 1);
            check($sformatf("tt%0d.sum", i),   s1,  tt[i].s);
            check($sformatf("tt%0d.carry", i), k1,  tt[i].c);
        end
        v1 = 1'b0;
        check("tt.carry_cnt", n1, 1);
        tick();
        check("tt.idle_valid", ov1, 0);

        // Multi-lane example
        step8(1'b1, 8'hF0, 8'hCC, 1'b0, "lanes");
        check("lanes.sum_const", s8, 8'h3C);
        check("lanes.carry_const", k8, 8'hC0);
        check("lanes.cnt_const", n8, 2);

        // Valid gating: outputs hold, counter holds
        step8(1'b0, 8'hFF, 8'hFF, 1'b0, "gate");
        check("gate.sum_hold", s8, 8'h3C);
        check("gate.cnt_hold", n8, 2);

        // Saturation with a 4-bit counter
        vs = 1'b1; a_s = 8'hFF; b_s = 8'hFF;
        tick(); check("sat.cnt1", ns, 8);
        tick(); check("sat.cnt2", ns, 15);
        tick(); check("sat.cnt3", ns, 15);
        cls = 1'b1;
        tick();
        check("sat.clr_cnt", ns, 0);
        check("sat.clr_valid", ovs, 1);
        check("sat.clr_carry", ks, 8'hFF);
        check("sat.clr_sum", ss, 8'h00);
        cls = 1'b0; vs = 1'b0;
        tick();
        check("sat.after_clr", ns, 0);

        // Back-to-back random valid beats
        for (int i = 0; i < 16; i++)
            step8(1'b1, 8'($urandom), 8'($urandom), 1'b0, $sformatf("b2b%0d", i));

        // Random mix of valid, idle and clear beats
        for (int i = 0; i < 80; i++)
            step8(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 15) == 0), $sformatf("rnd%0d", i));

        // Drive the 16-bit counter into saturation
        step8(1'b0, 8'h00, 8'h00, 1'b1, "preclr");
        for (int i = 0; i < 8200; i++)
            step8(1'b1, 8'hFF, 8'hFF, 1'b0, "sat16");
        check("sat16.const", n8, 16'hFFFF);

        // Asynchronous reset mid-cycle with live state
        step8(1'b1, 8'hFF, 8'h0F, 1'b0, "prerst");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst.ov8", ov8, 0);
        check("arst.sum8", s8, 0);
        check("arst.carry8", k8, 0);
        check("arst.cnt8", n8, 0);
        check("arst.carrys", ks, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step8(1'b0, 8'hAA, 8'h55, 1'b0, "post0");
        step8(1'b1, 8'h3F, 8'hF3, 1'b0, "post1");
        step8(1'b1, 8'h81, 8'h81, 1'b0, "post2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
